pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
- Fetch-stage program counter unit for the RV32I single-cycle core.
- Sits directly upstream of the instruction memory and drives its word-aligned byte address each cycle.
- Selects the next PC from three sources: sequential increment, redirect from branch/jump resolution, or the trap vector.
- Tracks fetch state: boot, run, stall, trap, and halt at end of program.

Parameters:
- IMEM_DEPTH, 21, number of 32-bit words in instruction memory; valid byte addresses are 0 .. IMEM_DEPTH*4-4.
- PROG_VALUE, 32, address/PC width in bits.
- RESET_VECTOR, 0, PC loaded on reset; must be word-aligned and inside IMEM.
- TRAP_VECTOR, 0, PC loaded after a trap is acknowledged.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hold the current PC; no advance.
- redirect_valid_i  input  1  take redirect_target_i as the next PC.
- redirect_target_i  input  PROG_VALUE  branch/jump target byte address.
- trap_ack_i  input  1  trap handler acknowledge; leave TRAP.
- addr  output  PROG_VALUE  current PC; drives instruction memory addr.
- pc_plus4_o  output  PROG_VALUE  addr+4, for JAL/JALR link.
- fetch_valid_o  output  1  addr is a legal fetch this cycle.
- trap_o  output  1  misaligned or out-of-range target pending.
- trap_cause_o  output  2  0 none, 1 misaligned, 2 out of range.

Behaviour:
- Reset: addr=RESET_VECTOR, fetch_valid_o=0, trap_o=0, trap_cause_o=0, state=BOOT. Reset asserted in any state, including mid-trap, returns to BOOT on the next edge.
- States:
  - BOOT: one cycle, fetch_valid_o=0, then RUN. PC is unchanged, so RESET_VECTOR is fetched first.
  - RUN: fetch_valid_o=1.
  - STALL: fetch_valid_o=1, PC held.
  - TRAP: fetch_valid_o=0, trap_o=1.
  - HALT: fetch_valid_o=0.
- Next-PC priority in RUN and STALL, highest first: redirect_valid_i, then stall_i, then sequential.
  - Redirect wins over a simultaneous stall.
  - stall_i alone: PC held, state=STALL. Deassert returns to RUN, and the held PC+4 becomes next.
  - Sequential: PC <= PC+4, modulo 2^PROG_VALUE.
- Redirect checks, evaluated combinationally on the target:
  - target[1:0]!=0: state=TRAP, cause=1, PC unchanged.
  - target > IMEM_DEPTH*4-4: state=TRAP, cause=2, PC unchanged.
  - Otherwise PC <= target. Latency is 1 cycle: the target appears on addr the edge after the redirect is sampled.
- Sequential end: in RUN with PC=IMEM_DEPTH*4-4, no redirect and no stall, go to HALT. PC stays at the last word; there is no wrap.
- HALT: only a legal redirect restarts; it loads the target and goes to RUN. An illegal redirect goes to TRAP. stall_i is ignored.
- TRAP:
  - trap_cause_o is held; redirect and stall are ignored.
  - trap_ack_i: PC <= TRAP_VECTOR, cause cleared, state=RUN on the next edge.
- pc_plus4_o is always addr+4, combinational.
- trap_o, fetch_valid_o and trap_cause_o are registered with state; trap_o=(state==TRAP).

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count_o [31:0], counting cycles with fetch_valid_o=1 and not STALL.
  - Adds output redirect_count_o [31:0], counting accepted legal redirects.
  - Both clear on rst and saturate at 32'hFFFF_FFFF.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Shared package pc_fetch_pkg holds:
  - typedef enum logic [2:0] fetch_state_t {BOOT, RUN, STALL, TRAP, HALT}
  - typedef enum logic [1:0] trap_cause_t {NONE, MISALIGN, RANGE}
  - localparam INSTR_BYTES=4
- Sub-module pc_target_check is natural: combinational, taking target and IMEM_DEPTH, producing legal and cause.
- Everything else stays flat.

Test Plan:
- Reset then free run, IMEM_DEPTH=21: addr holds 0 for two cycles (BOOT, then first fetch), then steps 4, 8, ... up to 80, then HALT with fetch_valid_o=0 and addr=80.
- stall_i high 3 cycles at addr=12: addr stays 12 for those cycles, then 16 follows; with PERF enabled, fetch_count_o does not increment while stalled.
- Redirect to 28 together with stall_i at addr=8: next addr=28, state RUN, and the stall is ignored.
- Redirect to 5: trap_o=1 and trap_cause_o=1 next cycle, addr stays put. trap_ack_i then gives addr=TRAP_VECTOR (0) and fetch_valid_o=1.
- Redirect to 84 (out of range): trap_cause_o=2. Assert rst during TRAP: next cycle is BOOT with addr=0 and trap_o=0.
- In HALT at addr=80, redirect to 16: addr=16 next cycle, RUN, fetch_valid_o=1, then addr=20 the following cycle.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch-stage program counter unit.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    STALL,
    TRAP,
    HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE,
    MISALIGN,
    RANGE
  } trap_cause_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Byte address of the last instruction word in an IMEM of the given depth.
  function automatic logic [31:0] last_word_addr(input int unsigned depth);
    return 32'(depth * INSTR_BYTES - INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pc_target_check.sv
// Combinational legality check of a redirect target against IMEM alignment and bounds.
module pc_target_check
  import pc_fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 21,
  parameter int unsigned PROG_VALUE = 32
) (
  input  logic [PROG_VALUE-1:0] target_i,
  output logic                  legal_o,
  output trap_cause_t           cause_o
);

  localparam logic [PROG_VALUE-1:0] LAST_ADDR = PROG_VALUE'(last_word_addr(IMEM_DEPTH));

  // Misalignment is reported ahead of range when both apply.
  always_comb begin
    legal_o = 1'b1;
    cause_o = NONE;
    if (target_i[1:0] != 2'b00) begin
      legal_o = 1'b0;
      cause_o = MISALIGN;
    end else if (target_i > LAST_ADDR) begin
      legal_o = 1'b0;
      cause_o = RANGE;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch-stage PC unit: sequential/redirect/trap next-PC selection with boot, stall, trap and halt.
// Optional performance counters are built when PC_FETCH_PERF_EN is defined.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH   = 21,
  parameter int unsigned PROG_VALUE   = 32,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned TRAP_VECTOR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [PROG_VALUE-1:0] redirect_target_i,
  input  logic                  trap_ack_i,
  output logic [PROG_VALUE-1:0] addr,
  output logic [PROG_VALUE-1:0] pc_plus4_o,
  output logic                  fetch_valid_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_count_o,
  output logic [31:0]           redirect_count_o
`endif
);

  localparam logic [PROG_VALUE-1:0] PC_LAST  = PROG_VALUE'(last_word_addr(IMEM_DEPTH));
  localparam logic [PROG_VALUE-1:0] PC_STEP  = PROG_VALUE'(INSTR_BYTES);
  localparam logic [PROG_VALUE-1:0] PC_RESET = PROG_VALUE'(RESET_VECTOR);
  localparam logic [PROG_VALUE-1:0] PC_TRAP  = PROG_VALUE'(TRAP_VECTOR);

  fetch_state_t          state_q, state_d;
  logic [PROG_VALUE-1:0] pc_q, pc_d;
  trap_cause_t           cause_q, cause_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  trap_q, trap_d;
  logic                  tgt_legal;
  trap_cause_t           tgt_cause;

  pc_target_check #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .PROG_VALUE (PROG_VALUE)
  ) u_target_check (
    .target_i (redirect_target_i),
    .legal_o  (tgt_legal),
    .cause_o  (tgt_cause)
  );

  // State, PC and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= PC_RESET;
      cause_q       <= NONE;
      fetch_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      fetch_valid_q <= fetch_valid_d;
      trap_q        <= trap_d;
    end
  end

  // Next state and next PC; redirect outranks stall, stall outranks sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, STALL: begin
        if (redirect_valid_i) begin
          if (tgt_legal) begin
            pc_d    = redirect_target_i;
            state_d = RUN;
          end else begin
            state_d = TRAP;
            cause_d = tgt_cause;
          end
        end else if (stall_i) begin
          state_d = STALL;
        end else if (pc_q == PC_LAST) begin
          state_d = HALT;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = RUN;
        end
      end
      HALT: begin
        if (redirect_valid_i) begin
          if (tgt_legal) begin
            pc_d    = redirect_target_i;
            state_d = RUN;
          end else begin
            state_d = TRAP;
            cause_d = tgt_cause;
          end
        end
      end
      TRAP: begin
        if (trap_ack_i) begin
          pc_d    = PC_TRAP;
          cause_d = NONE;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Status outputs follow the state they will be registered alongside.
  always_comb begin
    fetch_valid_d = 1'b0;
    trap_d        = 1'b0;
    case (state_d)
      RUN, STALL: fetch_valid_d = 1'b1;
      TRAP:       trap_d        = 1'b1;
      default: ;
    endcase
  end

  assign addr          = pc_q;
  assign pc_plus4_o    = pc_q + PC_STEP;
  assign fetch_valid_o = fetch_valid_q;
  assign trap_o        = trap_q;
  assign trap_cause_o  = 2'(cause_q);

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;
  logic        redirect_accept;

  assign redirect_accept = redirect_valid_i && tgt_legal &&
                           (state_q == RUN || state_q == STALL || state_q == HALT);

  // Saturating counters of advancing fetches and accepted redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (fetch_valid_q && state_q != STALL && fetch_cnt_q != 32'hFFFF_FFFF)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_accept && redirect_cnt_q != 32'hFFFF_FFFF)
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o    = fetch_cnt_q;
  assign redirect_count_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed table-driven bench for pc_fetch with IMEM_DEPTH=21 and zero reset/trap vectors.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        trap_ack_i;
  logic [31:0] addr;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count_o;
  logic [31:0] redirect_count_o;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch #(
    .IMEM_DEPTH   (21),
    .PROG_VALUE   (32),
    .RESET_VECTOR (0),
    .TRAP_VECTOR  (0)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .trap_ack_i        (trap_ack_i),
    .addr              (addr),
    .pc_plus4_o        (pc_plus4_o),
    .fetch_valid_o     (fetch_valid_o),
    .trap_o            (trap_o),
    .trap_cause_o      (trap_cause_o)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_count_o     (fetch_count_o),
    .redirect_count_o  (redirect_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] e_addr;
    logic        e_fv;
    logic        e_trap;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic rv, input logic [31:0] t,
                              input logic a, input logic [31:0] ea, input logic efv,
                              input logic etr, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.tgt = t; v.ack = a;
    v.e_addr = ea; v.e_fv = efv; v.e_trap = etr; v.e_cause = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1ns later.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] t,
                      input logic a);
    rst = r; stall_i = s; redirect_valid_i = rv; redirect_target_i = t; trap_ack_i = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int row, input logic [31:0] ea, input logic efv,
                            input logic etr, input logic [1:0] ec);
    check("addr", row, addr, ea);
    check("pc_plus4", row, pc_plus4_o, ea + 32'd4);
    check("fetch_valid", row, 32'(fetch_valid_o), 32'(efv));
    check("trap", row, 32'(trap_o), 32'(etr));
    check("trap_cause", row, 32'(trap_cause_o), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_target_i = '0; trap_ack_i = 1'b0;

    // reset, BOOT->RUN, free run to the last word, then HALT
    add(1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) add(0, 0, 0, 0, 0, 32'(4 * i), 1, 0, 0);
    add(0, 0, 0, 0, 0,  80, 0, 0, 0);
    add(0, 1, 0, 0, 0,  80, 0, 0, 0);
    // restart from HALT, redirect beats stall, stall for three cycles
    add(0, 0, 1, 16, 0, 16, 1, 0, 0);
    add(0, 0, 0, 0, 0,  20, 1, 0, 0);
    add(0, 0, 1, 8, 0,   8, 1, 0, 0);
    add(0, 1, 1, 28, 0, 28, 1, 0, 0);
    add(0, 0, 1, 12, 0, 12, 1, 0, 0);
    add(0, 1, 0, 0, 0,  12, 1, 0, 0);
    add(0, 1, 0, 0, 0,  12, 1, 0, 0);
    add(0, 1, 0, 0, 0,  12, 1, 0, 0);
    add(0, 0, 0, 0, 0,  16, 1, 0, 0);
    // misaligned trap, ignored inputs while trapped, acknowledge
    add(0, 0, 1, 5, 0,  16, 0, 1, 1);
    add(0, 1, 1, 40, 0, 16, 0, 1, 1);
    add(0, 0, 0, 0, 1,   0, 1, 0, 0);
    add(0, 0, 0, 0, 0,   4, 1, 0, 0);
    // out-of-range trap, reset during TRAP
    add(0, 0, 1, 84, 0,  4, 0, 1, 2);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 1, 0, 0);
    add(0, 0, 0, 0, 0,   4, 1, 0, 0);
    // last legal word as a target, then HALT, then illegal redirect from HALT
    add(0, 0, 1, 80, 0, 80, 1, 0, 0);
    add(0, 0, 0, 0, 0,  80, 0, 0, 0);
    add(0, 0, 1, 84, 0, 80, 0, 1, 2);
    add(0, 0, 0, 0, 1,   0, 1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].tgt, vecs[i].ack);
      check_outs(i, vecs[i].e_addr, vecs[i].e_fv, vecs[i].e_trap, vecs[i].e_cause);
    end

    // Hand sequence: stall then redirect, then reset in the middle of a stall.
    step(1, 0, 0, 0, 0);  check_outs(100, 0, 0, 0, 0);
`ifdef PC_FETCH_PERF_EN
    check("fetch_count", 100, fetch_count_o, 32'd0);
    check("redirect_count", 100, redirect_count_o, 32'd0);
`endif
    step(0, 0, 0, 0, 0);  check_outs(101, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);  check_outs(102, 4, 1, 0, 0);
    step(0, 0, 0, 0, 0);  check_outs(103, 8, 1, 0, 0);
    step(0, 1, 0, 0, 0);  check_outs(104, 8, 1, 0, 0);
    step(0, 1, 0, 0, 0);  check_outs(105, 8, 1, 0, 0);
    step(0, 0, 1, 8, 0);  check_outs(106, 8, 1, 0, 0);
`ifdef PC_FETCH_PERF_EN
    check("fetch_count", 106, fetch_count_o, 32'd3);
    check("redirect_count", 106, redirect_count_o, 32'd1);
`endif
    step(0, 1, 0, 0, 0);  check_outs(107, 8, 1, 0, 0);
    step(1, 1, 0, 0, 0);  check_outs(108, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);  check_outs(109, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
